// File: rtl/proyecto_nios2_qsys_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// proyecto_nios2_qsys_0_oci_dct_packer
//
// Producer side of the Nios II OCI data-trace compression path. Two-bit trace
// codes are shifted into a 30-bit accumulation buffer (newest code in the low
// bits). A frame {count, buffer} is handed to the trace store through a
// one-entry output register with a valid/ready handshake. A frame is emitted
// either when the 15th code arrives or when a flush request drains a partial
// buffer.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high; clears every register
//   code_valid   a trace code is offered
//   code         the trace code
//   code_ready   the packer accepts a code this cycle (registered terms only)
//   flush        single-cycle request to emit the partial frame
//   frame_valid  output register holds a frame
//   frame_data   {count, buffer}
//   frame_ready  trace store accepts the frame
//   dct_buffer   live accumulation buffer
//   dct_count    live number of codes held (0..SLOTS-1)
// ---------------------------------------------------------------------------
module proyecto_nios2_qsys_0_oci_dct_packer #(
  parameter int CODE_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            code_valid,
  input  logic [CODE_W-1:0]               code,
  output logic                            code_ready,
  input  logic                            flush,
  output logic                            frame_valid,
  output logic [CNT_W+CODE_W*SLOTS-1:0]   frame_data,
  input  logic                            frame_ready,
  output logic [CODE_W*SLOTS-1:0]         dct_buffer,
  output logic [CNT_W-1:0]                dct_count
);

  localparam int BUF_W   = CODE_W * SLOTS;
  localparam int FRAME_W = CNT_W + BUF_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

  // Accumulator state, decoded from count and flush_pend.
  localparam logic [1:0] ST_EMPTY      = 2'd0;
  localparam logic [1:0] ST_FILL       = 2'd1;
  localparam logic [1:0] ST_FLUSH_WAIT = 2'd2;

  logic [BUF_W-1:0]   buffer;
  logic [CNT_W-1:0]   count;
  logic               flush_pend;
  logic [1:0]         state;

  logic [FRAME_W-1:0] frame_p0;
  logic               vld_p0;

  logic               accept;
  logic               out_free;
  logic               full_load;
  logic               flush_load;
  logic               flush_done;
  logic [BUF_W-1:0]   buf_shift;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [CNT_W-1:0] cnt,
                                                    input logic [BUF_W-1:0] bits);
    return {cnt, bits};
  endfunction

  always_comb begin
    state = ST_EMPTY;
    if (flush_pend)
      state = ST_FLUSH_WAIT;
    else if (count != '0)
      state = ST_FILL;
  end

  // The full-slot stall looks only at the registered frame_valid, so the
  // last slot opens one cycle after the store drains the previous frame.
  assign code_ready = (state != ST_FLUSH_WAIT) && !((count == CNT_LAST) && vld_p0);
  assign accept     = code_valid && code_ready;
  assign buf_shift  = {buffer[BUF_W-CODE_W-1:0], code};
  assign out_free   = !vld_p0 || frame_ready;

  // code_ready guarantees the output register is empty when the last slot
  // is accepted, so a full frame never overwrites a pending one.
  assign full_load  = accept && (count == CNT_LAST);

  // Accept and flush load are exclusive: flush_pend blocks code_ready.
  assign flush_load = (state == ST_FLUSH_WAIT) && (count != '0) && out_free;
  assign flush_done = (state == ST_FLUSH_WAIT) && ((count == '0) || out_free);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer     <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (full_load || flush_load) begin
        buffer <= '0;
        count  <= '0;
      end else if (accept) begin
        buffer <= buf_shift;
        count  <= count + CNT_W'(1);
      end
      // A flush arriving while one is already pending is absorbed.
      flush_pend <= flush_pend ? !flush_done : flush;
    end
  end

  // ---- stage p0: output frame register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_p0 <= '0;
      vld_p0   <= 1'b0;
    end else begin
      if (full_load) begin
        frame_p0 <= pack_frame(CNT_FULL, buf_shift);
        vld_p0   <= 1'b1;
      end else if (flush_load) begin
        frame_p0 <= pack_frame(count, buffer);
        vld_p0   <= 1'b1;
      end else if (frame_ready) begin
        vld_p0   <= 1'b0;
      end
    end
  end

  assign frame_valid = vld_p0;
  assign frame_data  = frame_p0;
  assign dct_buffer  = buffer;
  assign dct_count   = count;

endmodule

// File: tb/tb_proyecto_nios2_qsys_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// Testbench for proyecto_nios2_qsys_0_oci_dct_packer. Expected frames are
// queued when stimulus is driven and compared when the store side accepts.
// ---------------------------------------------------------------------------
module tb_proyecto_nios2_qsys_0_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        frame_valid;
  logic [33:0] frame_data;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  int checks = 0;
  int errors = 0;

  logic [33:0] sb[$];
  logic [33:0] sb_exp;

  typedef struct {
    int          n;
    logic [29:0] codes;   // code i sits in bits [2i+1:2i], i=0 sent first
    bit          do_flush;
    logic [33:0] exp;
  } vec_t;

  vec_t vec[6];

  proyecto_nios2_qsys_0_oci_dct_packer #(
    .CODE_W(2), .SLOTS(15), .CNT_W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .code        (code),
    .code_ready  (code_ready),
    .flush       (flush),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [1:0] c);
    code_valid = 1'b1;
    code       = c;
    chk("send_ready", 64'(code_ready), 64'(1));
    step();
    code_valid = 1'b0;
  endtask

  // Store-side scoreboard: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got frame %0h expected none", frame_data);
      end else begin
        sb_exp = sb.pop_front();
        chk("sb_frame", 64'(frame_data), 64'(sb_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{15, 30'h15555555, 1'b0, 34'h3D5555555};
    vec[1] = '{3,  30'h0000001B, 1'b1, 34'h0C0000039};
    vec[2] = '{15, 30'h2AAAAAAA, 1'b0, 34'h3EAAAAAAA};
    vec[3] = '{5,  30'h0000039C, 1'b1, 34'h1400000DB};
    vec[4] = '{1,  30'h00000002, 1'b1, 34'h040000002};
    vec[5] = '{14, 30'h0FFFFFFF, 1'b1, 34'h38FFFFFFF};

    reset       = 1'b1;
    code_valid  = 1'b0;
    code        = 2'b00;
    flush       = 1'b0;
    frame_ready = 1'b1;
    step();
    step();
    chk("rst_fv",    64'(frame_valid), 64'(0));
    chk("rst_data",  64'(frame_data),  64'(0));
    chk("rst_count", 64'(dct_count),   64'(0));
    chk("rst_buf",   64'(dct_buffer),  64'(0));
    reset = 1'b0;
    step();
    chk("rst_ready", 64'(code_ready), 64'(1));

    // Table-driven frames with the store always ready.
    for (int t = 0; t < 6; t++) begin
      sb.push_back(vec[t].exp);
      for (int i = 0; i < vec[t].n; i++) begin
        send_code(vec[t].codes[2*i +: 2]);
        chk("vec_count", 64'(dct_count), 64'((i + 1 == 15) ? 0 : i + 1));
      end
      if (vec[t].do_flush) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("vec_flush_lat", 64'(frame_valid), 64'(0));
        step();
      end
      chk("vec_fv",    64'(frame_valid), 64'(1));
      chk("vec_data",  64'(frame_data),  64'(vec[t].exp));
      chk("vec_count0", 64'(dct_count),  64'(0));
      chk("vec_buf0",  64'(dct_buffer),  64'(0));
      step();
      chk("vec_fv_drop", 64'(frame_valid), 64'(0));
    end

    // Empty flush: no frame, ready returns after one cycle.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("eflush_ready_lo", 64'(code_ready),  64'(0));
    chk("eflush_fv",       64'(frame_valid), 64'(0));
    step();
    chk("eflush_ready_hi", 64'(code_ready),  64'(1));
    chk("eflush_fv2",      64'(frame_valid), 64'(0));

    // Backpressure: first frame held, last slot stalls.
    frame_ready = 1'b0;
    sb.push_back(34'h3EAAAAAAA);
    for (int i = 0; i < 15; i++) send_code(2'b10);
    chk("bp_fv",   64'(frame_valid), 64'(1));
    chk("bp_data", 64'(frame_data),  64'(34'h3EAAAAAAA));
    for (int i = 0; i < 14; i++) send_code(2'b11);
    chk("bp_count14", 64'(dct_count),  64'(14));
    chk("bp_ready0",  64'(code_ready), 64'(0));
    code_valid = 1'b1;
    code       = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_count", 64'(dct_count),  64'(14));
      chk("bp_hold_ready", 64'(code_ready), 64'(0));
      chk("bp_hold_data",  64'(frame_data), 64'(34'h3EAAAAAAA));
      chk("bp_hold_fv",    64'(frame_valid), 64'(1));
    end
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("bp_drain_fv",    64'(frame_valid), 64'(0));
    chk("bp_drain_ready", 64'(code_ready),  64'(1));
    chk("bp_drain_count", 64'(dct_count),   64'(14));
    sb.push_back(34'h3FFFFFFFF);
    step();
    code_valid = 1'b0;
    chk("bp2_fv",    64'(frame_valid), 64'(1));
    chk("bp2_data",  64'(frame_data),  64'(34'h3FFFFFFFF));
    chk("bp2_count", 64'(dct_count),   64'(0));
    frame_ready = 1'b1;
    step();

    // Accept and flush in the same cycle.
    send_code(2'b00);
    send_code(2'b01);
    sb.push_back(34'h0C0000007);
    code_valid = 1'b1;
    code       = 2'b11;
    flush      = 1'b1;
    chk("sim_ready", 64'(code_ready), 64'(1));
    step();
    code_valid = 1'b0;
    flush      = 1'b0;
    chk("sim_count", 64'(dct_count),   64'(3));
    chk("sim_ready_lo", 64'(code_ready), 64'(0));
    chk("sim_fv0",   64'(frame_valid), 64'(0));
    step();
    chk("sim_fv",    64'(frame_valid), 64'(1));
    chk("sim_data",  64'(frame_data),  64'(34'h0C0000007));
    step();

    // Flush behind a busy output register, with a repeated flush absorbed.
    frame_ready = 1'b0;
    sb.push_back(34'h3D5555555);
    for (int i = 0; i < 15; i++) send_code(2'b01);
    sb.push_back(34'h08000000A);
    send_code(2'b10);
    send_code(2'b10);
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    step();
    chk("b2b_fvA",   64'(frame_valid), 64'(1));
    chk("b2b_dataA", 64'(frame_data),  64'(34'h3D5555555));
    chk("b2b_ready", 64'(code_ready),  64'(0));
    frame_ready = 1'b1;
    step();
    chk("b2b_fvB",   64'(frame_valid), 64'(1));
    chk("b2b_dataB", 64'(frame_data),  64'(34'h08000000A));
    step();
    chk("b2b_fv_drop", 64'(frame_valid), 64'(0));
    step();
    chk("b2b_no_extra", 64'(frame_valid), 64'(0));

    // Asynchronous reset with a partial frame and a pending frame.
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_code(2'b01);
    for (int i = 0; i < 7; i++) send_code(2'b11);
    chk("mr_pre_fv",    64'(frame_valid), 64'(1));
    chk("mr_pre_count", 64'(dct_count),   64'(7));
    #2;
    reset = 1'b1;
    #1;
    chk("mr_fv",    64'(frame_valid), 64'(0));
    chk("mr_count", 64'(dct_count),   64'(0));
    chk("mr_buf",   64'(dct_buffer),  64'(0));
    chk("mr_data",  64'(frame_data),  64'(0));
    step();
    reset       = 1'b0;
    frame_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mr_post_fv", 64'(frame_valid), 64'(0));
    end
    chk("mr_post_ready", 64'(code_ready), 64'(1));

    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
